step_pulse_generator: RTL and testbench
=======================================

# step_pulse_generator

Avalon-MM slave that produces a motion command as a step/direction pulse train for a downstream two-phase stepper driver stage. Software programs step period, pulse width and step count, then starts a move. The block emits exactly COUNT step pulses at a fixed rate, holds direction stable around every pulse, and raises a completion interrupt. It sits between the Qsys interconnect and the driver's step/direction inputs, replacing software bit-banging of the step register.

## Interface
Parameters:
- DIR_SETUP, 4: clocks that coe_dir is held stable before the first step rising edge of a move (≥1).
- WIDTH_W, 16: width of the PULSE_WIDTH register.

Ports:
- csi_MCLK_clk  in  1  sole clock; all logic on rising edge.
- rsi_MRST_reset_n  in  1  asynchronous, active-low reset.
- avs_ctrl_address  in  3  word address.
- avs_ctrl_write / avs_ctrl_read  in  1  strobes; write has priority when both are high.
- avs_ctrl_writedata  in  32.
- avs_ctrl_byteenable  in  4  applies to PERIOD, PULSE_WIDTH, COUNT; ignored elsewhere.
- avs_ctrl_readdata  out  32  registered; fixed read latency 1.
- avs_ctrl_waitrequest  out  1  tied 0.
- coe_step  out  1  step pulse, active high.
- coe_dir  out  1  direction, 1 = forward.
- ins_irq  out  1  level interrupt = done & irq_en.

## Operation
Registers (unused bits read 0):
- 0 PERIOD[31:0]: clocks from one step rise to the next. Effective period = max(PERIOD, 2).
- 1 PULSE_WIDTH[WIDTH_W-1:0]: high time. Effective width = min(max(PULSE_WIDTH,1), eff_period−1).
- 2 COUNT[31:0]: steps per move.
- 3 CTRL: write bit0 start (self-clearing), bit1 dir, bit2 abort (self-clearing), bit3 irq_en. Read returns {irq_en,0,dir,0} in bits [3:0].
- 4 STATUS: bit0 busy (RO), bit1 done (sticky; write 1 to clear).
- 5 REMAIN (RO): steps not yet issued in the current or last move.

FSM states IDLE, SETUP, HIGH, LOW:
- IDLE: start with COUNT=0 → done=1, stays IDLE. Start with COUNT≠0 → REMAIN←COUNT, coe_dir←CTRL.dir, busy=1, clear done, go SETUP.
- SETUP: counts DIR_SETUP cycles, then HIGH.
- HIGH: coe_step=1; entering HIGH samples PERIOD/PULSE_WIDTH into shadow copies for that pulse and decrements REMAIN. After eff_width cycles → LOW.
- LOW: coe_step=0 until eff_period cycles since the rise; then HIGH if REMAIN≠0, else IDLE with busy=0, done=1.
- Abort (any non-IDLE state): next cycle coe_step=0, IDLE, busy=0, done=1; REMAIN keeps its value. Abort in IDLE has no effect.
- Start while busy is ignored; CTRL.dir and irq_en writes while busy update the register, but coe_dir only changes at the next start.
- PERIOD/PULSE_WIDTH writes while busy take effect at the next step rise. COUNT writes while busy affect only the next move.
- Start and abort in the same write: abort wins.
- Reset: coe_step=0, coe_dir=0, ins_irq=0, readdata=0, all registers 0, FSM IDLE.

## Timing
- Start write in cycle T: busy and coe_dir update at T+1; first coe_step rise at T+1+DIR_SETUP.
- Rise-to-rise spacing is exactly eff_period; high time is exactly eff_width.
- Last pulse: done=1 and busy=0 eff_period cycles after its rise. A new start in the next cycle gives a rise DIR_SETUP+1 cycles later.
- Read data appears one cycle after the read strobe. ins_irq follows done/irq_en with 1 cycle of latency.
- Reset assertion mid-pulse drops coe_step immediately (asynchronously).

## Test plan
- Reset values: hold reset_n=0 mid-move → coe_step=0, all reads 0; after release, STATUS=0.
- Basic move: PERIOD=10, PULSE_WIDTH=3, COUNT=5, dir=1, start at T → coe_dir=1 at T+1, rises at T+5,15,25,35,45, each high for 3 cycles, done/irq at T+55, REMAIN=0.
- Clamping: PERIOD=1, PULSE_WIDTH=0 → period 2, width 1; PERIOD=4, PULSE_WIDTH=9 → width 3.
- Abort: COUNT=10 with abort after the 3rd rise → coe_step=0 next cycle, done=1, REMAIN=7; start during busy ignored.
- Live update: change PERIOD 10→20 during pulse 2 → spacing 10 before pulse 3, 20 from pulse 3 onward.
- COUNT=0 start → done in 1 cycle, no pulses. Start+abort in the same write → no pulses.

Source files
------------

// File: rtl/step_pulse_generator.sv
// Avalon-MM step/direction pulse generator: emits COUNT step pulses at a programmed period and
// width, holding direction stable for DIR_SETUP clocks before the first rise of each move.
module step_pulse_generator #(
    parameter int unsigned DIR_SETUP = 4,
    parameter int unsigned WIDTH_W   = 16
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic        coe_step,
    output logic        coe_dir,
    output logic        ins_irq
);

    localparam logic [2:0]  AddrPeriod = 3'd0;
    localparam logic [2:0]  AddrWidth  = 3'd1;
    localparam logic [2:0]  AddrCount  = 3'd2;
    localparam logic [2:0]  AddrCtrl   = 3'd3;
    localparam logic [2:0]  AddrStatus = 3'd4;
    localparam logic [2:0]  AddrRemain = 3'd5;
    localparam logic [31:0] SetupLast  = 32'(DIR_SETUP - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_e;

    state_e             state_q;
    logic [31:0]        period_q;
    logic [WIDTH_W-1:0] width_q;
    logic [31:0]        count_q;
    logic [31:0]        remain_q;
    logic [31:0]        phase_q;
    logic [31:0]        eff_period_q;
    logic [31:0]        eff_width_q;
    logic               dir_q;
    logic               irq_en_q;
    logic               done_q;
    logic               irq_q;
    logic               step_q;
    logic               step_dir_q;
    logic [31:0]        rdata_q;

    logic        busy;
    logic        wr_period, wr_width, wr_count, wr_ctrl, wr_status;
    logic        start_req, abort_req;
    logic [31:0] per_eff, wid_raw, wid_eff;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return r;
    endfunction

    assign busy      = (state_q != StIdle);
    assign wr_period = avs_ctrl_write && (avs_ctrl_address == AddrPeriod);
    assign wr_width  = avs_ctrl_write && (avs_ctrl_address == AddrWidth);
    assign wr_count  = avs_ctrl_write && (avs_ctrl_address == AddrCount);
    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == AddrCtrl);
    assign wr_status = avs_ctrl_write && (avs_ctrl_address == AddrStatus);
    // Abort beats start when both arrive in one write.
    assign start_req = wr_ctrl && avs_ctrl_writedata[0] && !avs_ctrl_writedata[2];
    assign abort_req = wr_ctrl && avs_ctrl_writedata[2];

    always_comb begin
        per_eff = (period_q < 32'd2) ? 32'd2 : period_q;
        wid_raw = (width_q == '0) ? 32'd1 : 32'(width_q);
        wid_eff = (wid_raw > (per_eff - 32'd1)) ? (per_eff - 32'd1) : wid_raw;
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_q      <= StIdle;
            period_q     <= '0;
            width_q      <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            phase_q      <= '0;
            eff_period_q <= '0;
            eff_width_q  <= '0;
            dir_q        <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            step_q       <= 1'b0;
            step_dir_q   <= 1'b0;
        end else begin
            if (wr_period) begin
                period_q <= be_merge(period_q, avs_ctrl_writedata, avs_ctrl_byteenable);
            end
            if (wr_width) begin
                width_q <= WIDTH_W'(be_merge(32'(width_q), avs_ctrl_writedata,
                                             avs_ctrl_byteenable));
            end
            if (wr_count) begin
                count_q <= be_merge(count_q, avs_ctrl_writedata, avs_ctrl_byteenable);
            end
            if (wr_ctrl) begin
                dir_q    <= avs_ctrl_writedata[1];
                irq_en_q <= avs_ctrl_writedata[3];
            end
            // A completion in the same cycle as a W1C overrides the clear below.
            if (wr_status && avs_ctrl_writedata[1]) begin
                done_q <= 1'b0;
            end
            irq_q <= done_q && irq_en_q;

            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        if (count_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remain_q   <= count_q;
                            step_dir_q <= avs_ctrl_writedata[1];
                            done_q     <= 1'b0;
                            phase_q    <= '0;
                            state_q    <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    if (abort_req) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (phase_q == SetupLast) begin
                        state_q      <= StHigh;
                        step_q       <= 1'b1;
                        eff_period_q <= per_eff;
                        eff_width_q  <= wid_eff;
                        remain_q     <= remain_q - 32'd1;
                        phase_q      <= 32'd1;
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                StHigh: begin
                    if (abort_req) begin
                        step_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        if (phase_q >= eff_width_q) begin
                            step_q  <= 1'b0;
                            state_q <= StLow;
                        end
                        phase_q <= phase_q + 32'd1;
                    end
                end
                StLow: begin
                    if (abort_req) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (phase_q >= eff_period_q) begin
                        if (remain_q != '0) begin
                            state_q      <= StHigh;
                            step_q       <= 1'b1;
                            eff_period_q <= per_eff;
                            eff_width_q  <= wid_eff;
                            remain_q     <= remain_q - 32'd1;
                            phase_q      <= 32'd1;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            rdata_q <= '0;
        end else if (avs_ctrl_read && !avs_ctrl_write) begin
            case (avs_ctrl_address)
                AddrPeriod: rdata_q <= period_q;
                AddrWidth:  rdata_q <= 32'(width_q);
                AddrCount:  rdata_q <= count_q;
                AddrCtrl:   rdata_q <= {28'd0, irq_en_q, 1'b0, dir_q, 1'b0};
                AddrStatus: rdata_q <= {30'd0, done_q, busy};
                AddrRemain: rdata_q <= remain_q;
                default:    rdata_q <= '0;
            endcase
        end
    end

    assign avs_ctrl_readdata    = rdata_q;
    assign avs_ctrl_waitrequest = 1'b0;
    assign coe_step             = step_q;
    assign coe_dir              = step_dir_q;
    assign ins_irq              = irq_q;

endmodule

// File: tb/tb_step_pulse_generator.sv
// Bench for step_pulse_generator: register vector table plus timed move sequences checked
// through read and step-rise scoreboards.
module tb_step_pulse_generator;

    logic        clk;
    logic        rst_n;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        step;
    logic        dir;
    logic        irq;

    int unsigned cyc = 0;
    int          nvec = 0;
    int          nmis = 0;

    string       rq_name[$];
    logic [31:0] rq_exp[$];
    logic        rd_vld = 1'b0;

    int unsigned er_cyc[$];
    int unsigned er_w[$];
    logic        mon_en = 1'b1;
    logic        prev_step = 1'b0;
    int unsigned hi_cnt = 0;
    int unsigned cur_w = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[12];

    step_pulse_generator #(
        .DIR_SETUP(4),
        .WIDTH_W  (16)
    ) dut (
        .csi_MCLK_clk        (clk),
        .rsi_MRST_reset_n    (rst_n),
        .avs_ctrl_address    (address),
        .avs_ctrl_write      (write),
        .avs_ctrl_read       (read),
        .avs_ctrl_writedata  (writedata),
        .avs_ctrl_byteenable (byteenable),
        .avs_ctrl_readdata   (readdata),
        .avs_ctrl_waitrequest(waitrequest),
        .coe_step            (step),
        .coe_dir             (dir),
        .ins_irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Read scoreboard: expectation pushed with the strobe, compared when data is valid.
    always @(posedge clk) rd_vld <= read && !write && rst_n;
    always @(negedge clk) begin
        if (rd_vld) begin
            if (rq_exp.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL read_scoreboard: got 0x%0h, required no pending read", readdata);
            end else begin
                chk(rq_name.pop_front(), readdata, rq_exp.pop_front());
            end
        end
    end

    // Step monitor: every rise must match the next expected rise cycle and high time.
    always @(negedge clk) begin
        if (mon_en) begin
            if (step && !prev_step) begin
                if (er_cyc.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_rise: got rise at cycle %0d, required none", cyc);
                end else begin
                    chk("rise_cycle", cyc, er_cyc.pop_front());
                    cur_w  = er_w.pop_front();
                    hi_cnt = 1;
                end
            end else if (step) begin
                hi_cnt++;
            end else if (prev_step) begin
                chk("high_width", hi_cnt, cur_w);
            end
        end
        prev_step = step;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1);
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        rq_name.push_back(name);
        rq_exp.push_back(exp);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_rise(input int unsigned c, input int unsigned w);
        er_cyc.push_back(c);
        er_w.push_back(w);
    endtask

    task automatic setup_move(input logic [31:0] per, input logic [31:0] w,
                              input logic [31:0] cnt);
        wr(3'd0, per, 4'hF);
        wr(3'd1, w, 4'hF);
        wr(3'd2, cnt, 4'hF);
    endtask

    int unsigned t0;

    initial begin
        vt[0]  = '{3'd0, 32'h12345678, 4'hF, 32'h12345678};
        vt[1]  = '{3'd0, 32'hAABBCCDD, 4'h1, 32'h123456DD};
        vt[2]  = '{3'd0, 32'h00000000, 4'hC, 32'h000056DD};
        vt[3]  = '{3'd1, 32'hFFFF1234, 4'hF, 32'h00001234};
        vt[4]  = '{3'd1, 32'h0000ABCD, 4'h2, 32'h0000AB34};
        vt[5]  = '{3'd2, 32'hDEADBEEF, 4'hA, 32'hDE00BE00};
        vt[6]  = '{3'd2, 32'h11223344, 4'h5, 32'hDE22BE44};
        vt[7]  = '{3'd3, 32'h0000000A, 4'h0, 32'h0000000A};
        vt[8]  = '{3'd3, 32'h000000F5, 4'hF, 32'h00000000};
        vt[9]  = '{3'd4, 32'h00000002, 4'hF, 32'h00000000};
        vt[10] = '{3'd5, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        vt[11] = '{3'd6, 32'hFFFFFFFF, 4'hF, 32'h00000000};

        rst_n = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("waitrequest", 32'(waitrequest), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(3'd4, 32'd0, "rst_status");
        rd(3'd0, 32'd0, "rst_period");
        rd(3'd2, 32'd0, "rst_count");

        // Register write/readback table (byteenable, RO and unused bits; last CTRL entry
        // is start+abort together, which must not start a move).
        for (int i = 0; i < 12; i++) begin
            wr(vt[i].addr, vt[i].wd, vt[i].be);
            rd(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
        end
        rd(3'd4, 32'd0, "start_abort_status");

        // Basic move: period 10, width 3, five steps, forward, irq enabled.
        setup_move(32'd10, 32'd3, 32'd5);
        t0 = cyc;
        for (int k = 0; k < 5; k++) exp_rise(t0 + 5 + 10 * k, 3);
        wr(3'd3, 32'hB, 4'hF);
        chk("basic_dir", 32'(dir), 32'd1);
        rd(3'd4, 32'd1, "basic_busy");
        wait_cyc(t0 + 54);
        rd(3'd4, 32'd1, "basic_busy_last");
        chk("basic_irq_pre", 32'(irq), 32'd0);
        rd(3'd4, 32'd2, "basic_done");
        chk("basic_irq", 32'(irq), 32'd1);
        rd(3'd5, 32'd0, "basic_remain");
        chk("basic_rises_left", er_cyc.size(), 32'd0);
        wr(3'd4, 32'd2, 4'hF);
        @(posedge clk);
        #1;
        chk("basic_irq_clear", 32'(irq), 32'd0);

        // Clamp: period 1 -> 2, width 0 -> 1.
        setup_move(32'd1, 32'd0, 32'd3);
        t0 = cyc;
        for (int k = 0; k < 3; k++) exp_rise(t0 + 5 + 2 * k, 1);
        wr(3'd3, 32'h1, 4'hF);
        chk("clamp1_dir", 32'(dir), 32'd0);
        wait_cyc(t0 + 10);
        rd(3'd4, 32'd1, "clamp1_busy");
        rd(3'd4, 32'd2, "clamp1_done");
        chk("clamp1_rises_left", er_cyc.size(), 32'd0);
        wr(3'd4, 32'd2, 4'hF);

        // Clamp: width 9 with period 4 -> width 3.
        setup_move(32'd4, 32'd9, 32'd2);
        t0 = cyc;
        exp_rise(t0 + 5, 3);
        exp_rise(t0 + 9, 3);
        wr(3'd3, 32'h1, 4'hF);
        wait_cyc(t0 + 12);
        rd(3'd4, 32'd1, "clamp2_busy");
        rd(3'd4, 32'd2, "clamp2_done");
        chk("clamp2_rises_left", er_cyc.size(), 32'd0);
        wr(3'd4, 32'd2, 4'hF);

        // Abort after the third rise; a start while busy is ignored.
        setup_move(32'd10, 32'd3, 32'd10);
        t0 = cyc;
        exp_rise(t0 + 5, 3);
        exp_rise(t0 + 15, 3);
        exp_rise(t0 + 25, 2);
        wr(3'd3, 32'h3, 4'hF);
        wait_cyc(t0 + 10);
        wr(3'd3, 32'h1, 4'hF);
        chk("busy_start_dir", 32'(dir), 32'd1);
        wait_cyc(t0 + 26);
        wr(3'd3, 32'h4, 4'hF);
        chk("abort_step", 32'(step), 32'd0);
        rd(3'd4, 32'd2, "abort_status");
        rd(3'd5, 32'd7, "abort_remain");
        rd(3'd3, 32'd0, "abort_ctrl");
        chk("abort_dir_held", 32'(dir), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_rises_left", er_cyc.size(), 32'd0);
        wr(3'd4, 32'd2, 4'hF);

        // Live PERIOD update during pulse 2 applies from pulse 3.
        setup_move(32'd10, 32'd3, 32'd4);
        t0 = cyc;
        exp_rise(t0 + 5, 3);
        exp_rise(t0 + 15, 3);
        exp_rise(t0 + 25, 3);
        exp_rise(t0 + 45, 3);
        wr(3'd3, 32'h1, 4'hF);
        chk("live_dir", 32'(dir), 32'd0);
        wait_cyc(t0 + 16);
        wr(3'd0, 32'd20, 4'hF);
        wait_cyc(t0 + 64);
        rd(3'd4, 32'd1, "live_busy");
        rd(3'd4, 32'd2, "live_done");
        rd(3'd5, 32'd0, "live_remain");
        chk("live_rises_left", er_cyc.size(), 32'd0);
        wr(3'd4, 32'd2, 4'hF);

        // COUNT=0 start completes at once with no pulses.
        wr(3'd2, 32'd0, 4'hF);
        wr(3'd3, 32'h1, 4'hF);
        rd(3'd4, 32'd2, "count0_done");
        repeat (10) @(posedge clk);
        #1;
        wr(3'd4, 32'd2, 4'hF);

        // Start and abort in one write: nothing happens.
        wr(3'd2, 32'd3, 4'hF);
        wr(3'd3, 32'h5, 4'hF);
        rd(3'd4, 32'd0, "start_abort_idle");
        repeat (10) @(posedge clk);
        #1;

        // Reset asserted mid-pulse.
        setup_move(32'd10, 32'd5, 32'd5);
        t0 = cyc;
        wr(3'd3, 32'h3, 4'hF);
        rd(3'd0, 32'd10, "pre_reset_period");
        mon_en = 1'b0;
        wait_cyc(t0 + 6);
        chk("pre_reset_step", 32'(step), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_dir", 32'(dir), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        address = 3'd0;
        read    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_read", readdata, 32'd0);
        read  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        rd(3'd4, 32'd0, "post_reset_status");
        rd(3'd0, 32'd0, "post_reset_period");
        rd(3'd1, 32'd0, "post_reset_width");
        rd(3'd2, 32'd0, "post_reset_count");
        rd(3'd3, 32'd0, "post_reset_ctrl");
        rd(3'd5, 32'd0, "post_reset_remain");
        repeat (20) @(posedge clk);
        #1;
        chk("read_queue_left", rq_exp.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
